alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_slice_array.sv | 47 ++++
 rtl/alu_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, bit-cell modes and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHL = 2'b10,
        OP_SHR = 2'b11
    } op_t;

    // "Left" is the more significant neighbour: take-from-left is a one-bit logical right shift.
    typedef enum logic [1:0] {
        MODE_ADD        = 2'b00,
        MODE_SUB        = 2'b01,
        MODE_TAKE_LEFT  = 2'b10,
        MODE_TAKE_RIGHT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic mode_t op_to_mode(input op_t op);
        mode_t mode;
        case (op)
            OP_ADD:  mode = MODE_ADD;
            OP_SUB:  mode = MODE_SUB;
            OP_SHL:  mode = MODE_TAKE_RIGHT;
            default: mode = MODE_TAKE_LEFT;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/alu_slice_array.sv
// Stateless row of WIDTH add/sub/shift bit cells sharing one ripple carry chain.
module alu_slice_array
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mode_t            mode,
    output logic [WIDTH-1:0] y,
    output logic             carry_out,
    output logic             shift_out
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;
    logic [WIDTH+1:0] a_ext;

    assign is_sub = (mode == MODE_SUB);
    assign b_eff  = is_sub ? ~b : b;
    // Zero-padded on both ends so edge cells shift in 0 without special cases.
    assign a_ext  = {1'b0, a, 1'b0};

    // Carry chain kept in one block; subtraction enters with carry-in 1 (a + ~b + 1).
    always_comb begin
        c[0] = is_sub;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign sum[gi] = a[gi] ^ b_eff[gi] ^ c[gi];
            assign y[gi]   = (mode == MODE_TAKE_LEFT)  ? a_ext[gi+2] :
                             (mode == MODE_TAKE_RIGHT) ? a_ext[gi]   : sum[gi];
        end
    endgenerate

    assign carry_out = c[WIDTH];
    assign shift_out = (mode == MODE_TAKE_LEFT)  ? a[0] :
                       (mode == MODE_TAKE_RIGHT) ? a[WIDTH-1] : 1'b0;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshaked ADD/SUB in one cycle, bit-serial shifts one position per cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int SAW = $clog2(WIDTH);

    state_t           state_reg;
    op_t              op_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] b_reg;
    logic [SAW-1:0]   cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             zero_reg;

    logic [WIDTH-1:0] slice_y;
    logic             slice_co;
    logic             slice_so;

    alu_slice_array #(.WIDTH(WIDTH)) u_slices (
        .a         (work_reg),
        .b         (b_reg),
        .mode      (op_to_mode(op_reg)),
        .y         (slice_y),
        .carry_out (slice_co),
        .shift_out (slice_so)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= OP_ADD;
            work_reg   <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg    <= op_t'(op);
                        work_reg  <= a;
                        b_reg     <= b;
                        cnt_reg   <= b[SAW-1:0];
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_reg == OP_ADD || op_reg == OP_SUB) begin
                        result_reg <= slice_y;
                        carry_reg  <= slice_co;
                        zero_reg   <= (slice_y == '0);
                        state_reg  <= ST_DONE;
                    end else if (cnt_reg == '0) begin
                        result_reg <= work_reg;
                        carry_reg  <= 1'b0;
                        zero_reg   <= (work_reg == '0);
                        state_reg  <= ST_DONE;
                    end else begin
                        // carry tracks the bit pushed out by each step; the final step's value is kept.
                        work_reg  <= slice_y;
                        carry_reg <= slice_so;
                        cnt_reg   <= cnt_reg - 1'b1;
                        if (cnt_reg == SAW'(1)) begin
                            result_reg <= slice_y;
                            zero_reg   <= (slice_y == '0);
                            state_reg  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign carry     = carry_reg;
    assign zero      = zero_reg;

endmodule
